disp_scan: RTL and testbench
============================

// Module: disp_scan
// PURPOSE
//   Time-multiplexed scan driver for the elevator's multi-digit 7-segment display.
//   Sits directly upstream of hex2seg: each slot it selects one digit, presents that
//   digit's nibble and enable to hex2seg, and drives the active-low digit select lines.
//   Display values are double-buffered: a new value is applied only at a frame boundary,
//   so a digit is never shown half-updated. Per-digit blink supports door/arrival cues.
// PARAMETERS
//   DIGITS        4      number of digits scanned (>=2)
//   SCAN_DIV      50000  clk cycles per digit slot (>=BLANK+2)
//   BLANK         2      cycles at the start of each slot with all digits off (>=1)
//   BLINK_FRAMES  64     full frames per blink half-period (>=1)
// PORTS
//   clk         in   1           system clock, all logic on rising edge
//   rst_n       in   1           asynchronous, active-low reset
//   load        in   1           1-cycle strobe: capture data_in/digit_en/blink_mask
//   data_in     in   4*DIGITS    digit values, digit i = data_in[4i+3:4i]
//   digit_en    in   DIGITS      1 = digit i lit, 0 = blanked
//   blink_mask  in   DIGITS      1 = digit i blinks
//   hex_out     out  4           nibble of current digit, to hex2seg data_in
//   hex_en      out  1           enable of current digit, to hex2seg en
//   an_out      out  DIGITS      active-low digit select, at most one bit low
//   frame_tick  out  1           1-cycle pulse when the active buffer is (re)loaded
// BEHAVIOUR
//   Reset (async, rst_n=0): prescaler=0, idx=0, frame count=0, blink_phase=0 (lit),
//     staging/active buffers=0, pending=0; hex_out=0, hex_en=0, an_out=all 1,
//     frame_tick=0. Release is synchronous to clk; scan restarts from slot 0.
//   Prescaler: counts 0..SCAN_DIV-1 and wraps; slot_end = (prescaler==SCAN_DIV-1).
//   Digit index idx: increments on slot_end, wraps DIGITS-1 -> 0.
//   Frame end = slot_end while idx==DIGITS-1.
//   Buffering:
//     - load=1 -> staging <= inputs, pending <= 1. Repeated loads: the last one wins.
//     - At frame end: if load=1 in that same cycle, active <= inputs directly.
//       Otherwise, if pending, active <= staging. Either way pending <= 0 and
//       frame_tick=1 on the next cycle. No update -> frame_tick stays 0.
//   Blink: the frame counter counts frame ends 0..BLINK_FRAMES-1 and wraps.
//     On each wrap, blink_phase toggles.
//   Outputs (registered; one clk after prescaler/idx change):
//     - an_out = all 1 while prescaler < BLANK, else ~(1<<idx).
//     - hex_out = active nibble of digit idx, updated every cycle.
//     - hex_en = active_en[idx] & ~(active_blink[idx] & blink_phase).
//     - hex_en/hex_out stay driven during BLANK; only an_out blanks.
//   Width rules: prescaler width clog2(SCAN_DIV); idx width clog2(DIGITS);
//     no arithmetic overflow beyond the stated wraps.
//   Reset mid-frame: all state returns to reset values at once. Pending loads are lost.
// TESTING (DIGITS=4, SCAN_DIV=4, BLANK=1, BLINK_FRAMES=2)
//   1 reset: hold rst_n=0 -> an_out=4'b1111, hex_en=0, hex_out=0. Release ->
//     an_out sequence 1111,1110,1110,1110 then 1111,1101,... period 16 cycles.
//   2 load data_in=16'h4321, digit_en=4'hF, blink_mask=0 mid-frame -> outputs keep the
//     old value until the frame end. Next frame: hex_out=1,2,3,4 in slots 0..3;
//     frame_tick pulses exactly once.
//   3 load 16'h1111 then 16'h2222 in the same frame -> next frame shows 2 in all digits.
//     Load coincident with frame end -> applied at once, frame_tick next cycle.
//   4 blink_mask=4'b0010, digit_en=4'hF -> digit 1 hex_en: 1 for 2 frames, 0 for 2
//     frames, repeating. Other digits always 1. digit_en=4'b1110 -> digit 0 hex_en=0.
//   5 assert rst_n=0 in slot 2 with a load pending -> immediate reset outputs.
//     After release, the display shows 0-valued, disabled digits; the pending value
//     is discarded.
//   6 check: an_out never has more than one 0 bit in any cycle, and is all-1 in the
//     first cycle of every slot.

Source files
------------

// File: rtl/disp_scan.sv
// Time-multiplexed scan driver for a multi-digit 7-segment display.
// Double-buffered digit values switch only at frame boundaries; per-digit blink support.
module disp_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            hex_out,
    output logic                  hex_en,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic                  pending_q, pending_d;
    logic [4*DIGITS-1:0]   stg_data_q, stg_data_d;
    logic [DIGITS-1:0]     stg_en_q, stg_en_d;
    logic [DIGITS-1:0]     stg_blink_q, stg_blink_d;
    logic [4*DIGITS-1:0]   act_data_q, act_data_d;
    logic [DIGITS-1:0]     act_en_q, act_en_d;
    logic [DIGITS-1:0]     act_blink_q, act_blink_d;
    logic [3:0]            hex_out_q, hex_out_d;
    logic                  hex_en_q, hex_en_d;
    logic [DIGITS-1:0]     an_out_q, an_out_d;
    logic                  frame_tick_q, frame_tick_d;

    logic slot_end;
    logic frame_end;

    always_comb begin
        slot_end      = (presc_q == PRESC_LAST);
        frame_end     = slot_end && (idx_q == IDX_LAST);

        presc_d       = slot_end ? '0 : presc_q + 1'b1;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        stg_data_d  = stg_data_q;
        stg_en_d    = stg_en_q;
        stg_blink_d = stg_blink_q;
        pending_d   = pending_q;
        if (load) begin
            stg_data_d  = data_in;
            stg_en_d    = digit_en;
            stg_blink_d = blink_mask;
            pending_d   = 1'b1;
        end

        // A load landing exactly on the frame end bypasses staging so it is not delayed a frame.
        act_data_d   = act_data_q;
        act_en_d     = act_en_q;
        act_blink_d  = act_blink_q;
        frame_tick_d = 1'b0;
        if (frame_end) begin
            pending_d = 1'b0;
            if (load) begin
                act_data_d   = data_in;
                act_en_d     = digit_en;
                act_blink_d  = blink_mask;
                frame_tick_d = 1'b1;
            end else if (pending_q) begin
                act_data_d   = stg_data_q;
                act_en_d     = stg_en_q;
                act_blink_d  = stg_blink_q;
                frame_tick_d = 1'b1;
            end
        end

        an_out_d  = (presc_q < BLANK_END) ? '1 : ~(DIGITS'(1) << idx_q);
        hex_out_d = act_data_q[{idx_q, 2'b00} +: 4];
        hex_en_d  = act_en_q[idx_q] & ~(act_blink_q[idx_q] & blink_phase_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pending_q     <= 1'b0;
            stg_data_q    <= '0;
            stg_en_q      <= '0;
            stg_blink_q   <= '0;
            act_data_q    <= '0;
            act_en_q      <= '0;
            act_blink_q   <= '0;
            hex_out_q     <= '0;
            hex_en_q      <= 1'b0;
            an_out_q      <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            pending_q     <= pending_d;
            stg_data_q    <= stg_data_d;
            stg_en_q      <= stg_en_d;
            stg_blink_q   <= stg_blink_d;
            act_data_q    <= act_data_d;
            act_en_q      <= act_en_d;
            act_blink_q   <= act_blink_d;
            hex_out_q     <= hex_out_d;
            hex_en_q      <= hex_en_d;
            an_out_q      <= an_out_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign hex_out    = hex_out_q;
    assign hex_en     = hex_en_q;
    assign an_out     = an_out_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: reset table, directed buffering/blink/reset sequences, and a
// randomized run, all checked against a cycle-count based reference model.
module tb_disp_scan;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLANK        = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_LEN    = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  digit_en;
    logic [3:0]  blink_mask;
    logic [3:0]  hex_out;
    logic        hex_en;
    logic [3:0]  an_out;
    logic        frame_tick;

    disp_scan #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .digit_en(digit_en),
        .blink_mask(blink_mask), .hex_out(hex_out), .hex_en(hex_en), .an_out(an_out),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: everything derived from the number of cycles since reset release.
    int          m_n;
    int          m_frames;
    logic [15:0] m_act_d, m_stg_d;
    logic [3:0]  m_act_e, m_act_b, m_stg_e, m_stg_b;
    bit          m_pend;
    int          last_p, last_ix;

    typedef struct {
        logic        ld;
        logic [15:0] d;
        logic [3:0]  e;
        logic [3:0]  b;
        logic [3:0]  exp_an;
        logic        exp_en;
        logic [3:0]  exp_hex;
        logic        exp_tick;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_frames = 0; m_pend = 0;
        m_act_d = '0; m_act_e = '0; m_act_b = '0;
        m_stg_d = '0; m_stg_e = '0; m_stg_b = '0;
    endtask

    task automatic cyc(input logic ld, input logic [15:0] d, input logic [3:0] e, input logic [3:0] b);
        int p, ix;
        bit phase, fe, tick;
        logic [3:0] exp_an, exp_hex;
        logic exp_en;
        load = ld; data_in = d; digit_en = e; blink_mask = b;
        p      = m_n % SCAN_DIV;
        ix     = (m_n / SCAN_DIV) % DIGITS;
        phase  = ((m_frames / BLINK_FRAMES) % 2) == 1;
        exp_an = (p < BLANK) ? 4'hF : ~(4'b0001 << ix);
        exp_hex = m_act_d[ix*4 +: 4];
        exp_en = m_act_e[ix] & ~(m_act_b[ix] & phase);
        fe     = (p == SCAN_DIV - 1) && (ix == DIGITS - 1);
        tick   = 0;
        if (fe) begin
            if (ld) begin
                m_act_d = d; m_act_e = e; m_act_b = b; tick = 1;
            end else if (m_pend) begin
                m_act_d = m_stg_d; m_act_e = m_stg_e; m_act_b = m_stg_b; tick = 1;
            end
            m_frames++;
        end
        if (ld) begin
            m_stg_d = d; m_stg_e = e; m_stg_b = b;
        end
        m_pend = fe ? 1'b0 : (m_pend | ld);
        m_n++;
        last_p = p; last_ix = ix;
        @(posedge clk); #1;
        load = 1'b0;
        chk("an_out", an_out, exp_an);
        chk("hex_out", hex_out, exp_hex);
        chk("hex_en", hex_en, exp_en);
        chk("frame_tick", frame_tick, tick);
        chk("an_onehot", ($countones(~an_out) <= 1), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, data_in, digit_en, blink_mask);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, data_in, digit_en, blink_mask);
            if (frame_tick) break;
        end
        chk("tick_seen", frame_tick, 1);
    endtask

    task automatic goto_phase(input int ph);
        for (int i = 0; i < 40 && (m_n % FRAME_LEN) != ph; i++) idle(1);
    endtask

    vec_t tbl[17];
    logic [3:0] an_seq[17];

    initial begin
        int ticks, ones;
        an_seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                   4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
        for (int i = 0; i < 17; i++)
            tbl[i] = '{ld: 1'b0, d: 16'h0, e: 4'h0, b: 4'h0, exp_an: an_seq[i],
                       exp_en: 1'b0, exp_hex: 4'h0, exp_tick: 1'b0};

        // Reset values
        rst_n = 1'b0; load = 1'b0; data_in = '0; digit_en = '0; blink_mask = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_an", an_out, 4'hF);
        chk("rst_hex_en", hex_en, 0);
        chk("rst_hex_out", hex_out, 0);
        chk("rst_tick", frame_tick, 0);
        rst_n = 1'b1;

        // Scan sequence after release
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].ld, tbl[i].d, tbl[i].e, tbl[i].b);
            chk("tbl_an", an_out, tbl[i].exp_an);
            chk("tbl_hex_en", hex_en, tbl[i].exp_en);
            chk("tbl_hex_out", hex_out, tbl[i].exp_hex);
            chk("tbl_tick", frame_tick, tbl[i].exp_tick);
        end

        // Mid-frame load held until frame end, then shown in order
        cyc(1'b1, 16'h4321, 4'hF, 4'h0);
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (frame_tick) ticks++;
            if (ticks == 0) chk("old_hold", hex_out, 0);
            else if (last_p == 2) chk("slot_hex", hex_out, last_ix + 1);
        end
        chk("tick_once", ticks, 1);

        // Last of two loads in a frame wins
        goto_phase(3);
        cyc(1'b1, 16'h1111, 4'hF, 4'h0);
        idle(2);
        cyc(1'b1, 16'h2222, 4'hF, 4'h0);
        wait_tick();
        for (int i = 0; i < FRAME_LEN; i++) begin
            idle(1);
            if (last_p == 2) chk("last_wins", hex_out, 2);
        end

        // Load coincident with frame end applies immediately
        goto_phase(FRAME_LEN - 1);
        cyc(1'b1, 16'h5555, 4'hF, 4'h0);
        chk("tick_coincident", frame_tick, 1);
        idle(1);
        chk("coincident_hex", hex_out, 5);

        // Blink on digit 1
        cyc(1'b1, 16'h4321, 4'hF, 4'b0010);
        wait_tick();
        ones = 0;
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            idle(1);
            if (last_p == 2 && last_ix == 1 && hex_en) ones++;
            if (last_p == 2 && last_ix == 0) chk("noblink_en", hex_en, 1);
        end
        chk("blink_duty", ones, 2);

        // Disabled digit 0
        cyc(1'b1, 16'h4321, 4'b1110, 4'h0);
        wait_tick();
        for (int i = 0; i < FRAME_LEN; i++) begin
            idle(1);
            if (last_p == 2 && last_ix == 0) chk("dig0_off", hex_en, 0);
        end

        // Asynchronous reset in slot 2 with a load pending
        goto_phase(2 * SCAN_DIV);
        cyc(1'b1, 16'h9999, 4'hF, 4'hF);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("arst_an", an_out, 4'hF);
        chk("arst_hex_en", hex_en, 0);
        chk("arst_hex_out", hex_out, 0);
        chk("arst_tick", frame_tick, 0);
        model_reset();
        load = 1'b0; data_in = '0; digit_en = '0; blink_mask = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            idle(1);
            if (last_p == 2) begin
                chk("post_rst_en", hex_en, 0);
                chk("post_rst_hex", hex_out, 0);
            end
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
